// File: rtl/demux1x4_reg_if.sv
// demux1x4_reg bus: one producer-side stream and
// four registered consumer channels with counters.
interface demux1x4_reg_if #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 8
);
   logic [1:0]             sel;
   logic [DATA_WIDTH-1:0]  in_data;
   logic                   in_valid;
   logic                   in_ready;
   logic [DATA_WIDTH-1:0]  out_data0;
   logic [DATA_WIDTH-1:0]  out_data1;
   logic [DATA_WIDTH-1:0]  out_data2;
   logic [DATA_WIDTH-1:0]  out_data3;
   logic [3:0]             out_valid;
   logic [3:0]             out_ready;
   logic [COUNT_WIDTH-1:0] count0;
   logic [COUNT_WIDTH-1:0] count1;
   logic [COUNT_WIDTH-1:0] count2;
   logic [COUNT_WIDTH-1:0] count3;

   modport master (
      output sel,
      output in_data,
      output in_valid,
      input  in_ready,
      input  out_data0,
      input  out_data1,
      input  out_data2,
      input  out_data3,
      input  out_valid,
      output out_ready,
      input  count0,
      input  count1,
      input  count2,
      input  count3
   );

   modport slave (
      input  sel,
      input  in_data,
      input  in_valid,
      output in_ready,
      output out_data0,
      output out_data1,
      output out_data2,
      output out_data3,
      output out_valid,
      input  out_ready,
      output count0,
      output count1,
      output count2,
      output count3
   );
endinterface

// File: rtl/demux1x4_reg.sv
// Registered 1-to-4 demultiplexer: one input stream
// routed by sel into four one-word channel registers.
module demux1x4_reg #(
   parameter int DATA_WIDTH  = 8,
   parameter int COUNT_WIDTH = 8
) (
   input logic CLK,
   input logic RST,
   input logic CE,
   demux1x4_reg_if.slave bus
);

   logic [DATA_WIDTH-1:0]  data_q [4];
   logic [COUNT_WIDTH-1:0] cnt_q  [4];
   logic [3:0]             vld_q;

   logic                   rdy;
   logic                   acc;
   logic [3:0]             ld;
   logic [3:0]             drn;

   // Ready depends only on the targeted channel's
   // occupancy and its consumer, never on in_valid.
   always_comb begin
      rdy = CE & (~vld_q[bus.sel] | bus.out_ready[bus.sel]);
      acc = CE & bus.in_valid & rdy;
      ld  = 4'b0000;
      if (acc) begin
         ld[bus.sel] = 1'b1;
      end
      drn = {4{CE}} & vld_q & bus.out_ready;
   end

   // Per-channel holding register, valid flag and
   // saturating accept counter; reset beats CE.
   always_ff @(posedge CLK) begin
      if (RST) begin
         vld_q <= 4'b0000;
         for (int k = 0; k < 4; k++) begin
            data_q[k] <= '0;
            cnt_q[k]  <= '0;
         end
      end else if (CE) begin
         for (int k = 0; k < 4; k++) begin
            if (ld[k]) begin
               data_q[k] <= bus.in_data;
               vld_q[k]  <= 1'b1;
               if (cnt_q[k] != '1) begin
                  cnt_q[k] <= cnt_q[k] + COUNT_WIDTH'(1);
               end
            end else if (drn[k]) begin
               vld_q[k] <= 1'b0;
            end
         end
      end
   end

   assign bus.in_ready  = rdy;
   assign bus.out_valid = vld_q;
   assign bus.out_data0 = data_q[0];
   assign bus.out_data1 = data_q[1];
   assign bus.out_data2 = data_q[2];
   assign bus.out_data3 = data_q[3];
   assign bus.count0    = cnt_q[0];
   assign bus.count1    = cnt_q[1];
   assign bus.count2    = cnt_q[2];
   assign bus.count3    = cnt_q[3];

endmodule
